// File: rtl/led_matrix_scanner_pkg.sv
// Shared types and constants for the 8x8 LED matrix scanner.
// Contents: matrix geometry, scan state enum, row/column types and the
// row-strobe encoding helper (active-low one-hot).
package led_matrix_pkg;
   localparam int NUM_ROWS  = 8;
   localparam int NUM_COLS  = 8;
   localparam int NUM_SLOTS = 16;

   typedef enum logic [1:0] {
      OFF   = 2'd0,
      BLANK = 2'd1,
      DRIVE = 2'd2
   } scan_state_t;

   typedef logic [2:0]          row_idx_t;
   typedef logic [NUM_COLS-1:0] col_t;

   localparam logic [3:0] LAST_SLOT = 4'(NUM_SLOTS - 1);
   localparam row_idx_t   LAST_ROW  = 3'(NUM_ROWS - 1);

   // Active-low strobe pattern that selects exactly one row.
   function automatic col_t row_strobe(input row_idx_t idx);
      return ~(8'h01 << idx);
   endfunction
endpackage

// File: rtl/led_matrix_scanner_if.sv
// Back-buffer write port of the LED matrix scanner.
// Signals: wr_valid/wr_ready handshake, wr_row (target row), wr_data (column
// bits, bit0 = column 0). master = writer (CPU / board top), slave = scanner.
interface led_matrix_scanner_if;
   import led_matrix_pkg::*;

   logic     wr_valid;
   logic     wr_ready;
   row_idx_t wr_row;
   col_t     wr_data;

   modport master (output wr_valid, output wr_row, output wr_data, input wr_ready);
   modport slave  (input wr_valid, input wr_row, input wr_data, output wr_ready);
endinterface

// File: rtl/led_matrix_scanner_frame_buffer.sv
// Double-buffered 8x8 framebuffer.
// Ports: clock, reset_n (sync, active-low), wr_en/wr_row/wr_data write into the
// back bank, swap flips front/back, rd_row/rd_data read the front bank
// combinationally.
module led_frame_buffer
   import led_matrix_pkg::*;
(
   input  logic     clock,
   input  logic     reset_n,
   input  logic     wr_en,
   input  row_idx_t wr_row,
   input  col_t     wr_data,
   input  logic     swap,
   input  row_idx_t rd_row,
   output col_t     rd_data
);
   logic [NUM_ROWS-1:0][NUM_COLS-1:0] bank0_r;
   logic [NUM_ROWS-1:0][NUM_COLS-1:0] bank1_r;
   logic                              front_sel_r;

   // Bank storage: writes target the bank not on display; swap exchanges roles.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         bank0_r     <= {(NUM_ROWS * NUM_COLS){1'b0}};
         bank1_r     <= {(NUM_ROWS * NUM_COLS){1'b0}};
         front_sel_r <= 1'b0;
      end else begin
         if (wr_en) begin
            if (front_sel_r) begin
               bank0_r[wr_row] <= wr_data;
            end else begin
               bank1_r[wr_row] <= wr_data;
            end
         end
         if (swap) begin
            front_sel_r <= ~front_sel_r;
         end
      end
   end

   // Front-bank read for the row currently being scanned.
   always_comb begin
      if (front_sel_r) begin
         rd_data = bank1_r[rd_row];
      end else begin
         rd_data = bank0_r[rd_row];
      end
   end
endmodule

// File: rtl/led_matrix_scanner.sv
// Time-multiplexed scan controller for the 8x8 LED matrix.
// Ports: clock, reset_n (sync, active-low), enable (0 blanks the matrix),
// wr (back-buffer write port), swap_req/swap_pending (frame-boundary buffer
// swap), brightness/brightness_we (global 16-level PWM), row (active-low
// strobes), d (column data), frame_start (pulse as row 0 enters BLANK).
// All outputs are registered and lag the scan state by one cycle.
module led_matrix_scanner
   import led_matrix_pkg::*;
#(
   parameter int         SLOT_CYCLES      = 105,
   parameter int         BLANK_CYCLES     = 16,
   parameter logic [3:0] RESET_BRIGHTNESS = 4'd15
)(
   input  logic                clock,
   input  logic                reset_n,
   input  logic                enable,
   led_matrix_scanner_if.slave wr,
   input  logic                swap_req,
   output logic                swap_pending,
   input  logic [3:0]          brightness,
   input  logic                brightness_we,
   output col_t                row,
   output col_t                d,
   output logic                frame_start
);
   localparam int CNT_MAX = (SLOT_CYCLES > BLANK_CYCLES) ? SLOT_CYCLES : BLANK_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

   scan_state_t      state_r, state_s;
   row_idx_t         idx_r, idx_s;
   logic [3:0]       slot_r, slot_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic [3:0]       bright_lat_r, bright_lat_s;
   logic [3:0]       bright_act_r, bright_act_s;
   logic             pend_r, pend_s;
   logic             ready_r;
   logic             boundary_s;
   logic             swap_s;
   logic             wr_en_s;
   logic             lit_s;
   col_t             front_row_s;
   col_t             row_r;
   col_t             d_r;
   logic             fs_r;

   assign wr_en_s = wr.wr_valid && ready_r;
   // Swap only happens for a request already pending before this boundary.
   assign swap_s  = boundary_s && pend_r;
   assign lit_s   = (state_r == DRIVE) && (slot_r < bright_act_r);

   led_frame_buffer u_fb (
      .clock   (clock),
      .reset_n (reset_n),
      .wr_en   (wr_en_s),
      .wr_row  (wr.wr_row),
      .wr_data (wr.wr_data),
      .swap    (swap_s),
      .rd_row  (idx_r),
      .rd_data (front_row_s)
   );

   // Next-state logic for the scan FSM, counters, brightness and swap request.
   always_comb begin
      state_s      = state_r;
      idx_s        = idx_r;
      slot_s       = slot_r;
      cnt_s        = cnt_r;
      bright_act_s = bright_act_r;
      boundary_s   = 1'b0;

      // A write of the brightness in the same cycle as BLANK entry is honoured.
      if (brightness_we) begin
         bright_lat_s = brightness;
      end else begin
         bright_lat_s = bright_lat_r;
      end

      if (!enable) begin
         state_s = OFF;
         idx_s   = 3'd0;
         slot_s  = 4'd0;
         cnt_s   = {CNT_W{1'b0}};
      end else begin
         case (state_r)
            OFF: begin
               state_s      = BLANK;
               idx_s        = 3'd0;
               slot_s       = 4'd0;
               cnt_s        = {CNT_W{1'b0}};
               bright_act_s = bright_lat_s;
               boundary_s   = 1'b1;
            end
            BLANK: begin
               if (cnt_r == BLANK_LAST) begin
                  state_s = DRIVE;
                  slot_s  = 4'd0;
                  cnt_s   = {CNT_W{1'b0}};
               end else begin
                  cnt_s = cnt_r + CNT_W'(1);
               end
            end
            DRIVE: begin
               if (cnt_r == SLOT_LAST) begin
                  cnt_s = {CNT_W{1'b0}};
                  if (slot_r == LAST_SLOT) begin
                     state_s      = BLANK;
                     slot_s       = 4'd0;
                     idx_s        = idx_r + 3'd1;
                     bright_act_s = bright_lat_s;
                     // Leaving the last row wraps the index: this is the frame boundary.
                     boundary_s   = (idx_r == LAST_ROW);
                  end else begin
                     slot_s = slot_r + 4'd1;
                  end
               end else begin
                  cnt_s = cnt_r + CNT_W'(1);
               end
            end
            default: begin
               state_s = OFF;
               idx_s   = 3'd0;
               slot_s  = 4'd0;
               cnt_s   = {CNT_W{1'b0}};
            end
         endcase
      end

      if (swap_s) begin
         pend_s = 1'b0;
      end else if (swap_req) begin
         pend_s = 1'b1;
      end else begin
         pend_s = pend_r;
      end
   end

   // State, counter and output registers; outputs follow the registered state.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_r      <= OFF;
         idx_r        <= 3'd0;
         slot_r       <= 4'd0;
         cnt_r        <= {CNT_W{1'b0}};
         bright_lat_r <= RESET_BRIGHTNESS;
         bright_act_r <= RESET_BRIGHTNESS;
         pend_r       <= 1'b0;
         ready_r      <= 1'b1;
         row_r        <= 8'hFF;
         d_r          <= 8'h00;
         fs_r         <= 1'b0;
      end else begin
         state_r      <= state_s;
         idx_r        <= idx_s;
         slot_r       <= slot_s;
         cnt_r        <= cnt_s;
         bright_lat_r <= bright_lat_s;
         bright_act_r <= bright_act_s;
         pend_r       <= pend_s;
         ready_r      <= ~pend_s;
         row_r        <= lit_s ? row_strobe(idx_r) : 8'hFF;
         d_r          <= lit_s ? front_row_s : 8'h00;
         fs_r         <= (state_r == BLANK) && (cnt_r == {CNT_W{1'b0}}) && (idx_r == 3'd0);
      end
   end

   assign row          = row_r;
   assign d            = d_r;
   assign frame_start  = fs_r;
   assign swap_pending = pend_r;
   assign wr.wr_ready  = ready_r;
endmodule
